// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// Port 0 is instruction fetch, port 1 is load/store. A port may lock the RAM
// for read-modify-write sequences. The lock is force-released after
// LOCK_TIMEOUT consecutive idle cycles from the owner.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// UNLOCKED | both ports arbitrate round-robin
// LOCK0    | port 0 owns the RAM; only port 0 may be granted
// LOCK1    | port 1 owns the RAM; only port 1 may be granted
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic                  p0_lock,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_ack,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic                  p1_lock,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_ack,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  typedef enum logic [1:0] {UNLOCKED, LOCK0, LOCK1} state_t;

  localparam logic [7:0] TIMEOUT_TC = 8'(LOCK_TIMEOUT);

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  rr_last_q, rr_last_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_port_q, resp_port_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  logic owner_req, owner_gnt, owner_lock;
  logic [7:0] cnt_inc;

  // Grant selection: lock owner only, otherwise round-robin on conflict.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!rst) begin
      case (state_q)
        LOCK0:   p0_gnt = p0_req;
        LOCK1:   p1_gnt = p1_req;
        default: begin
          if (p0_req && p1_req) begin
            // rr_last holds the most recently granted port; the other wins.
            p0_gnt = rr_last_q;
            p1_gnt = !rr_last_q;
          end else begin
            p0_gnt = p0_req;
            p1_gnt = p1_req;
          end
        end
      endcase
    end
  end

  // RAM drive from the winner; everything idles at zero without a grant.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (p0_gnt) begin
      mem_we   = p0_we;
      mem_addr = p0_addr;
      mem_din  = p0_wdata;
    end else if (p1_gnt) begin
      mem_we   = p1_we;
      mem_addr = p1_addr;
      mem_din  = p1_wdata;
    end
  end

  // Response routing: ack the recorded port, hold the other port's data.
  always_comb begin
    p0_ack   = resp_valid_q && !resp_port_q && !rst;
    p1_ack   = resp_valid_q &&  resp_port_q && !rst;
    p0_rdata = rst ? '0 : (p0_ack ? mem_dout : rdata0_q);
    p1_rdata = rst ? '0 : (p1_ack ? mem_dout : rdata1_q);
    rdata0_d     = p0_rdata;
    rdata1_d     = p1_rdata;
    resp_valid_d = p0_gnt || p1_gnt;
    resp_port_d  = p1_gnt;
    rr_last_d    = p1_gnt ? 1'b1 : (p0_gnt ? 1'b0 : rr_last_q);
  end

  // Lock FSM next state and idle timeout counter.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_req  = (state_q == LOCK0) ? p0_req  : p1_req;
    owner_gnt  = (state_q == LOCK0) ? p0_gnt  : p1_gnt;
    owner_lock = (state_q == LOCK0) ? p0_lock : p1_lock;
    cnt_inc    = cnt_q + 8'd1;
    case (state_q)
      LOCK0, LOCK1: begin
        if (owner_gnt || owner_req) begin
          cnt_d = 8'd0;
          if (owner_gnt && !owner_lock) state_d = UNLOCKED;
        end else if (cnt_inc == TIMEOUT_TC) begin
          cnt_d   = 8'd0;
          state_d = UNLOCKED;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        cnt_d = 8'd0;
        if (p0_gnt && p0_lock)      state_d = LOCK0;
        else if (p1_gnt && p1_lock) state_d = LOCK1;
      end
    endcase
  end

  // State registers with synchronous reset; an in-flight response is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= UNLOCKED;
      cnt_q        <= 8'd0;
      rr_last_q    <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_port_q  <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_last_q    <= rr_last_d;
      resp_valid_q <= resp_valid_d;
      resp_port_q  <= resp_port_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port synchronous RAM: 8-bit address, 8-bit data, write-first, 1-cycle read latency.
- Port 0 is the instruction fetch path; port 1 is the load/store path.
- Grants at most one access per cycle using round-robin priority.
- Supports a lock for atomic read-modify-write sequences, with a timeout guard.
- Routes each response back to the requester that issued the access.

Parameters:
- ADDR_WIDTH, 8, address width; matches the RAM.
- DATA_WIDTH, 8, data width; matches the RAM.
- LOCK_TIMEOUT, 16, idle cycles after which a held lock is force-released. Range 1..255.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- p0_req  in  1  port 0 access request.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_lock  in  1  port 0: hold ownership after this access.
- p0_addr  in  ADDR_WIDTH  port 0 address.
- p0_wdata  in  DATA_WIDTH  port 0 write data.
- p0_gnt  out  1  port 0 request accepted this cycle (combinational).
- p0_ack  out  1  port 0 response valid (registered).
- p0_rdata  out  DATA_WIDTH  port 0 response data.
- p1_*  same set as port 0, for port 1.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_din  out  DATA_WIDTH  RAM write data.
- mem_dout  in  DATA_WIDTH  RAM registered read data.

Behaviour:
- Handshake: a requester holds req/we/lock/addr/wdata stable until it sees gnt=1 in the same cycle. Its next request may be presented the following cycle.
- Throughput: one access per cycle.
- Grant (combinational, gated by rst): at most one gnt asserted per cycle.
  - Only one req: that port wins.
  - Both req, no lock: the port not granted most recently wins. The rr_last register resets to 1, so port 0 wins the first conflict.
  - Lock held: only the owner may be granted. The other port's gnt stays 0 regardless of req.
- Memory drive:
  - On a grant: mem_we = winner we; mem_addr and mem_din come from the winner.
  - With no grant: mem_we=0, mem_addr=0, mem_din=0.
  - mem_we is never 1 without a gnt.
- Response pipeline:
  - Registered resp_valid and resp_port, set in the grant cycle.
  - The next cycle, pX_ack=1 for the recorded port only and pX_rdata=mem_dout.
  - Reads return stored data. Writes return the written data (write-first RAM).
  - Latency is exactly 1 cycle, grant to ack, for both reads and writes.
  - The pX_rdata of the non-acked port holds its previous value.
- Lock state machine, states UNLOCKED, LOCK0, LOCK1:
  - UNLOCKED -> LOCKn on a granted port n request with lock=1.
  - LOCKn -> UNLOCKED on a granted port n request with lock=0 (that access still completes).
  - LOCKn -> UNLOCKED when the timeout counter reaches LOCK_TIMEOUT.
- Timeout counter:
  - Counts consecutive cycles in LOCKn with pn_req=0.
  - Clears on any owner request or on leaving LOCKn.
  - At timeout the lock is released in the same edge. The other port becomes eligible from the next cycle.
- rr_last updates on every grant, including grants made while locked.
- Reset (synchronous), including mid-operation:
  - gnt=0, ack=0, rdata=0, mem_we=0, state UNLOCKED, counter=0, rr_last=1, resp_valid=0.
  - An in-flight response is dropped; no ack follows the reset cycle.
  - A request presented during rst is not granted and is not written.

Test Plan:
- Single read: preload addr 0x10=0xA5; p0 read 0x10 -> p0_gnt same cycle, p0_ack next cycle with p0_rdata=0xA5, p1_ack=0.
- Conflict round-robin: both req continuously (p0 read 0x01, p1 read 0x02) for 4 cycles -> grants alternate p0,p1,p0,p1; each ack one cycle later to the matching port.
- Write-then-read: p1 write 0x20=0x3C -> p1_ack with rdata=0x3C; the next cycle p0 read 0x20 returns 0x3C.
- Lock RMW:
  - p1 read 0x30 with lock=1, then p1 write 0x30=0x31 with lock=0.
  - p0 requests throughout -> p0_gnt=0 until p1's unlocking write is granted, then p0 is granted the following cycle.
- Lock timeout, LOCK_TIMEOUT=4: p0 locks then drops req; p1 requesting -> p1_gnt=0 for 4 cycles, p1_gnt=1 in the 5th cycle after p0's last grant.
- Reset mid-access: p0 read granted, rst=1 in the next cycle -> p0_ack=0, all outputs 0. After rst=0, p1 wins a p0/p1 conflict? No: the port 0 path wins the first conflict (rr_last=1).
